uvmt_cv32e40x_rvfi_obi_beat_tracker: RTL and testbench

- Passive tracker sitting directly upstream of the RVFI coverage/assertion checkers.
- Snoops the core's data-side OBI bus, counts completed OBI beats per retiring memory instruction, and emits a one-cycle observation record at each memory retirement.
- Downstream covers use the record to confirm split-transfer, push/pop and table-jump data behaviour against what actually happened on the bus: beat count, split flag, first-beat address match.
- Also flags bus/retire bookkeeping inconsistencies.

---
 rtl/uvmt_cv32e40x_rvfi_obi_pkg.sv | 23 ++
 rtl/uvmt_cv32e40x_obi_outstanding_fifo.sv | 58 +++++
 rtl/uvmt_cv32e40x_rvfi_obi_beat_tracker.sv | 120 ++++++++++++
 tb/tb_uvmt_cv32e40x_rvfi_obi_beat_tracker.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uvmt_cv32e40x_rvfi_obi_pkg.sv
// Shared types for the RVFI/OBI beat tracker: FIFO entry, beat accumulator
// and the word-align mask used for first-beat address comparison.
package uvmt_cv32e40x_rvfi_obi_pkg;

  localparam int unsigned ACC_CNT_W = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
  } obi_entry_t;

  typedef struct packed {
    logic [ACC_CNT_W-1:0] count;
    logic [31:0]          first_addr;
    logic                 we_any;
    logic                 valid_first;
  } beat_acc_t;

  function automatic logic [31:0] word_align_mask();
    return 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/uvmt_cv32e40x_obi_outstanding_fifo.sv
// Outstanding OBI transaction FIFO: entries pushed on grant, popped on rvalid.
// Pop is evaluated before push so a full FIFO may push and pop in one cycle.
module uvmt_cv32e40x_obi_outstanding_fifo
  import uvmt_cv32e40x_rvfi_obi_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push,
  input  obi_entry_t push_data,
  input  logic       pop,
  output obi_entry_t head_c,
  output logic       pop_ok_c,
  output logic       overflow_c,
  output logic       underflow_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  obi_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push_ok;

  always_comb begin
    empty       = (count == '0);
    full        = (count == CW'(DEPTH));
    pop_ok_c    = pop && !empty;
    push_ok     = push && (!full || pop_ok_c);
    overflow_c  = push && !push_ok;
    underflow_c = pop && empty;
    head_c      = mem[rd_ptr];
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok_c) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push_ok) - CW'(pop_ok_c);
    end
  end

endmodule

// File: rtl/uvmt_cv32e40x_rvfi_obi_beat_tracker.sv
// Attributes completed data-side OBI beats to retiring memory instructions and
// emits a registered observation record per memory retirement.
module uvmt_cv32e40x_rvfi_obi_beat_tracker
  import uvmt_cv32e40x_rvfi_obi_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NMEM  = 1,
  parameter int unsigned BEATW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rvfi_valid,
  input  logic              rvfi_trap,
  input  logic [4*NMEM-1:0] rvfi_mem_rmask,
  input  logic [4*NMEM-1:0] rvfi_mem_wmask,
  input  logic [31:0]       rvfi_mem_addr,
  input  logic              obi_req,
  input  logic              obi_gnt,
  input  logic [31:0]       obi_addr,
  input  logic              obi_we,
  input  logic              obi_rvalid,
  output logic              obs_valid,
  output logic [BEATW-1:0]  obs_beats,
  output logic              obs_split,
  output logic              obs_we_any,
  output logic              obs_addr_match,
  output logic              obs_trap,
  output logic              err_overflow,
  output logic              err_underflow,
  output logic              err_nobeat
);

  localparam logic [ACC_CNT_W-1:0] BEAT_MAX = ACC_CNT_W'((2 ** BEATW) - 1);

  obi_entry_t push_data;
  obi_entry_t head;
  logic       pop_ok;
  logic       overflow;
  logic       underflow;
  beat_acc_t  acc;
  beat_acc_t  acc_next;
  logic       mem_retire;
  logic       addr_match;

  assign push_data = '{addr: obi_addr, we: obi_we};

  uvmt_cv32e40x_obi_outstanding_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push        (obi_req && obi_gnt),
    .push_data   (push_data),
    .pop         (obi_rvalid),
    .head_c      (head),
    .pop_ok_c    (pop_ok),
    .overflow_c  (overflow),
    .underflow_c (underflow)
  );

  // Accumulator including this cycle's beat, so a same-cycle rvalid counts toward a retirement.
  always_comb begin
    acc_next = acc;
    if (pop_ok) begin
      if (acc.count == '0) begin
        acc_next.first_addr  = head.addr;
        acc_next.valid_first = 1'b1;
      end
      if (acc.count != BEAT_MAX) begin
        acc_next.count = acc.count + 1'b1;
      end
      acc_next.we_any = acc.we_any | head.we;
    end
    mem_retire = rvfi_valid && (((rvfi_mem_rmask | rvfi_mem_wmask) != '0) || rvfi_trap);
    addr_match = acc_next.valid_first &&
                 ((acc_next.first_addr & word_align_mask()) == (rvfi_mem_addr & word_align_mask()));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc            <= '0;
      obs_valid      <= 1'b0;
      obs_beats      <= '0;
      obs_split      <= 1'b0;
      obs_we_any     <= 1'b0;
      obs_addr_match <= 1'b0;
      obs_trap       <= 1'b0;
      err_overflow   <= 1'b0;
      err_underflow  <= 1'b0;
      err_nobeat     <= 1'b0;
    end else begin
      obs_valid <= mem_retire;
      if (mem_retire) begin
        obs_beats      <= BEATW'(acc_next.count);
        obs_split      <= (acc_next.count >= ACC_CNT_W'(2));
        obs_we_any     <= acc_next.we_any;
        obs_addr_match <= addr_match;
        obs_trap       <= rvfi_trap;
        acc            <= '0;
      end else begin
        obs_beats      <= '0;
        obs_split      <= 1'b0;
        obs_we_any     <= 1'b0;
        obs_addr_match <= 1'b0;
        obs_trap       <= 1'b0;
        acc            <= acc_next;
      end
      if (overflow) begin
        err_overflow <= 1'b1;
      end
      if (underflow) begin
        err_underflow <= 1'b1;
      end
      if (mem_retire && !rvfi_trap && (acc_next.count == '0)) begin
        err_nobeat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uvmt_cv32e40x_rvfi_obi_beat_tracker.sv
// Scoreboard bench for the RVFI/OBI beat tracker: expected records are queued
// at each memory retirement and compared when obs_valid pulses.
module tb_uvmt_cv32e40x_rvfi_obi_beat_tracker;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NMEM  = 1;
  localparam int unsigned BEATW = 5;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              rvfi_valid;
  logic              rvfi_trap;
  logic [4*NMEM-1:0] rvfi_mem_rmask;
  logic [4*NMEM-1:0] rvfi_mem_wmask;
  logic [31:0]       rvfi_mem_addr;
  logic              obi_req;
  logic              obi_gnt;
  logic [31:0]       obi_addr;
  logic              obi_we;
  logic              obi_rvalid;
  logic              obs_valid;
  logic [BEATW-1:0]  obs_beats;
  logic              obs_split;
  logic              obs_we_any;
  logic              obs_addr_match;
  logic              obs_trap;
  logic              err_overflow;
  logic              err_underflow;
  logic              err_nobeat;

  typedef struct packed {
    logic [BEATW-1:0] beats;
    logic             split;
    logic             we_any;
    logic             addr_match;
    logic             trap;
  } rec_t;

  rec_t exp_q[$];
  rec_t got_rec;
  rec_t exp_rec;
  int   n_cmp = 0;
  int   n_mis = 0;

  uvmt_cv32e40x_rvfi_obi_beat_tracker #(
    .DEPTH (DEPTH),
    .NMEM  (NMEM),
    .BEATW (BEATW)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rvfi_valid     (rvfi_valid),
    .rvfi_trap      (rvfi_trap),
    .rvfi_mem_rmask (rvfi_mem_rmask),
    .rvfi_mem_wmask (rvfi_mem_wmask),
    .rvfi_mem_addr  (rvfi_mem_addr),
    .obi_req        (obi_req),
    .obi_gnt        (obi_gnt),
    .obi_addr       (obi_addr),
    .obi_we         (obi_we),
    .obi_rvalid     (obi_rvalid),
    .obs_valid      (obs_valid),
    .obs_beats      (obs_beats),
    .obs_split      (obs_split),
    .obs_we_any     (obs_we_any),
    .obs_addr_match (obs_addr_match),
    .obs_trap       (obs_trap),
    .err_overflow   (err_overflow),
    .err_underflow  (err_underflow),
    .err_nobeat     (err_nobeat)
  );

  always #5 clk_i = ~clk_i;

  function automatic rec_t mk_rec(input int b, input bit s, input bit w, input bit m, input bit t);
    rec_t r;
    r.beats      = BEATW'(b);
    r.split      = s;
    r.we_any     = w;
    r.addr_match = m;
    r.trap       = t;
    return r;
  endfunction

  task automatic clear_inputs();
    rvfi_valid     = 1'b0;
    rvfi_trap      = 1'b0;
    rvfi_mem_rmask = '0;
    rvfi_mem_wmask = '0;
    rvfi_mem_addr  = '0;
    obi_req        = 1'b0;
    obi_gnt        = 1'b0;
    obi_addr       = '0;
    obi_we         = 1'b0;
    obi_rvalid     = 1'b0;
  endtask

  // Advance one cycle, then score any observation record against the queue.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (obs_valid !== 1'b0) begin
      got_rec = {obs_beats, obs_split, obs_we_any, obs_addr_match, obs_trap};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL obs_unexpected: got record %b (beats=%0d), required no record", got_rec, obs_beats);
      end else begin
        exp_rec = exp_q.pop_front();
        if (got_rec !== exp_rec) begin
          n_mis++;
          $display("FAIL obs_record: got beats=%0d split=%b we=%b match=%b trap=%b, required beats=%0d split=%b we=%b match=%b trap=%b",
                   got_rec.beats, got_rec.split, got_rec.we_any, got_rec.addr_match, got_rec.trap,
                   exp_rec.beats, exp_rec.split, exp_rec.we_any, exp_rec.addr_match, exp_rec.trap);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    n_cmp++;
    if ({obs_valid, obs_beats, obs_split, obs_we_any, obs_addr_match, obs_trap,
         err_overflow, err_underflow, err_nobeat} !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {obs_valid, obs_beats, obs_split, obs_we_any, obs_addr_match, obs_trap,
                err_overflow, err_underflow, err_nobeat});
    end
    rst_i = 1'b0;
  endtask

  task automatic test_aligned_load();
    obi_req = 1'b1; obi_gnt = 1'b1; obi_addr = 32'h1000; step();
    obi_rvalid = 1'b1; step();
    rvfi_valid = 1'b1; rvfi_mem_rmask = 4'hF; rvfi_mem_addr = 32'h1000;
    exp_q.push_back(mk_rec(1, 0, 0, 1, 0));
    step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL aligned_load_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete();
    end
    n_cmp++;
    if ({err_overflow, err_underflow, err_nobeat} !== 3'b000) begin
      n_mis++; $display("FAIL aligned_load_errs: got %b, required 000", {err_overflow, err_underflow, err_nobeat});
    end
  endtask

  task automatic test_split_store();
    obi_req = 1'b1; obi_gnt = 1'b1; obi_we = 1'b1; obi_addr = 32'h1000; step();
    obi_req = 1'b1; obi_gnt = 1'b1; obi_we = 1'b1; obi_addr = 32'h1004; step();
    obi_rvalid = 1'b1; step();
    obi_rvalid = 1'b1; step();
    rvfi_valid = 1'b1; rvfi_mem_wmask = 4'hC; rvfi_mem_addr = 32'h1002;
    exp_q.push_back(mk_rec(2, 1, 1, 1, 0));
    step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL split_store_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  // Six write beats with a non-memory retirement in the middle; one record only.
  task automatic test_push_six();
    for (int i = 0; i < 6; i++) begin
      obi_req = 1'b1; obi_gnt = 1'b1; obi_we = 1'b1;
      obi_addr = 32'h2FFC - 32'(4 * i);
      if (i > 0) obi_rvalid = 1'b1;
      if (i == 3) rvfi_valid = 1'b1;
      step();
    end
    obi_rvalid = 1'b1; step();
    rvfi_valid = 1'b1; rvfi_mem_wmask = 4'hF; rvfi_mem_addr = 32'h2FFC;
    exp_q.push_back(mk_rec(6, 1, 1, 1, 0));
    step();
    step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL push_six_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    obi_req = 1'b1; obi_gnt = 1'b1; obi_addr = 32'h3000; step();
    obi_rvalid = 1'b1;
    obi_req = 1'b1; obi_gnt = 1'b1; obi_addr = 32'h3004;
    rvfi_valid = 1'b1; rvfi_mem_rmask = 4'hF; rvfi_mem_addr = 32'h3000;
    exp_q.push_back(mk_rec(1, 0, 0, 1, 0));
    step();
    obi_rvalid = 1'b1;
    rvfi_valid = 1'b1; rvfi_mem_rmask = 4'hF; rvfi_mem_addr = 32'h3004;
    exp_q.push_back(mk_rec(1, 0, 0, 1, 0));
    step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL back_to_back_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_addr_mismatch();
    obi_req = 1'b1; obi_gnt = 1'b1; obi_addr = 32'h4000; step();
    obi_rvalid = 1'b1;
    rvfi_valid = 1'b1; rvfi_mem_rmask = 4'h3; rvfi_mem_addr = 32'h4010;
    exp_q.push_back(mk_rec(1, 0, 0, 0, 0));
    step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL addr_mismatch_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_trap_nobeat();
    rvfi_valid = 1'b1; rvfi_trap = 1'b1; rvfi_mem_rmask = 4'hF; rvfi_mem_addr = 32'h5000;
    exp_q.push_back(mk_rec(0, 0, 0, 0, 1));
    step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL trap_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete();
    end
    n_cmp++;
    if (err_nobeat !== 1'b0) begin
      n_mis++; $display("FAIL trap_nobeat: got err_nobeat=%b, required 0", err_nobeat);
    end
    rvfi_valid = 1'b1; rvfi_mem_rmask = 4'hF; rvfi_mem_addr = 32'h5000;
    exp_q.push_back(mk_rec(0, 0, 0, 0, 0));
    step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL nobeat_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete();
    end
    n_cmp++;
    if (err_nobeat !== 1'b1) begin
      n_mis++; $display("FAIL nobeat_set: got err_nobeat=%b, required 1", err_nobeat);
    end
    step();
    step();
    n_cmp++;
    if (err_nobeat !== 1'b1) begin
      n_mis++; $display("FAIL nobeat_sticky: got err_nobeat=%b, required 1", err_nobeat);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      obi_req = 1'b1; obi_gnt = 1'b1; obi_addr = 32'h6000 + 32'(4 * i); step();
    end
    n_cmp++;
    if ({err_overflow, err_underflow} !== 2'b10) begin
      n_mis++; $display("FAIL overflow_set: got ovf/udf=%b, required 10", {err_overflow, err_underflow});
    end
    step(); step(); step();
    n_cmp++;
    if (err_overflow !== 1'b1) begin
      n_mis++; $display("FAIL overflow_sticky: got %b, required 1", err_overflow);
    end
    do_reset();
    n_cmp++;
    if ({err_overflow, err_underflow, err_nobeat} !== 3'b000) begin
      n_mis++; $display("FAIL overflow_reset_clear: got %b, required 000", {err_overflow, err_underflow, err_nobeat});
    end
  endtask

  // Full FIFO push+pop is legal; rvalid on empty is underflow and not counted.
  task automatic test_full_push_pop_underflow();
    for (int i = 0; i < DEPTH; i++) begin
      obi_req = 1'b1; obi_gnt = 1'b1; obi_addr = 32'h6000 + 32'(4 * i); step();
    end
    obi_req = 1'b1; obi_gnt = 1'b1; obi_addr = 32'h6010; obi_rvalid = 1'b1; step();
    n_cmp++;
    if (err_overflow !== 1'b0) begin
      n_mis++; $display("FAIL full_push_pop_ovf: got %b, required 0", err_overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      obi_rvalid = 1'b1; step();
    end
    n_cmp++;
    if (err_underflow !== 1'b0) begin
      n_mis++; $display("FAIL drain_udf: got %b, required 0", err_underflow);
    end
    obi_rvalid = 1'b1; step();
    n_cmp++;
    if ({err_overflow, err_underflow} !== 2'b01) begin
      n_mis++; $display("FAIL underflow_set: got ovf/udf=%b, required 01", {err_overflow, err_underflow});
    end
    rvfi_valid = 1'b1; rvfi_mem_rmask = 4'hF; rvfi_mem_addr = 32'h6000;
    exp_q.push_back(mk_rec(5, 1, 0, 1, 0));
    step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL underflow_acc_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete();
    end
    do_reset();
    obi_req = 1'b1; obi_gnt = 1'b1; obi_addr = 32'h6100; obi_rvalid = 1'b1; step();
    n_cmp++;
    if (err_underflow !== 1'b1) begin
      n_mis++; $display("FAIL empty_push_pop_udf: got %b, required 1", err_underflow);
    end
  endtask

  task automatic test_reset_discard();
    do_reset();
    obi_req = 1'b1; obi_gnt = 1'b1; obi_addr = 32'h7000; step();
    obi_rvalid = 1'b1; step();
    obi_req = 1'b1; obi_gnt = 1'b1; obi_addr = 32'h7100; step();
    do_reset();
    obi_req = 1'b1; obi_gnt = 1'b1; obi_addr = 32'h7200; step();
    obi_rvalid = 1'b1; step();
    rvfi_valid = 1'b1; rvfi_mem_rmask = 4'hF; rvfi_mem_addr = 32'h7200;
    exp_q.push_back(mk_rec(1, 0, 0, 1, 0));
    step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL reset_discard_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete();
    end
    n_cmp++;
    if ({err_overflow, err_underflow, err_nobeat} !== 3'b000) begin
      n_mis++; $display("FAIL reset_discard_errs: got %b, required 000", {err_overflow, err_underflow, err_nobeat});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    test_reset();
    test_aligned_load();
    test_split_store();
    test_push_six();
    test_back_to_back();
    test_addr_mismatch();
    test_trap_nobeat();
    test_overflow();
    test_full_push_pop_underflow();
    test_reset_discard();
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
